// File: rtl/ct_f_spsram_lane_init_if.sv
// Access bus of the lane-enabled single-port SRAM wrapper, including the
// initialisation-sweep request and busy/done handshake.
interface ct_f_spsram_lane_init_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 92
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  INIT_REQ;
  logic                  INIT_BUSY;
  logic                  INIT_DONE;

  modport master (
    output A, CEN, GWEN, WEN, D, INIT_REQ,
    input  Q, INIT_BUSY, INIT_DONE
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D, INIT_REQ,
    output Q, INIT_BUSY, INIT_DONE
  );
endinterface

// File: rtl/ct_f_spsram_lane_init.sv
// Single-port SRAM wrapper with LANE_NUM independently writable lanes and a
// hardware sweep that fills every entry with INIT_VALUE after reset or on
// request. Each lane is one inferred block RAM with a registered,
// write-first read port.

// One lane: inferred block RAM, registered read, new data shown on a write.
module fpga_ram #(
  parameter int WIDTH      = 23,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write-first port: a written word is also returned on the read register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout      <= mem[addr];
    end
  end
endmodule

module ct_f_spsram_lane_init #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    LANE_WIDTH = 23,
  parameter int                    LANE_NUM   = 4,
  parameter logic [LANE_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                   CLK,
  input  logic                   RST_B,
  ct_f_spsram_lane_init_if.slave bus
);
  localparam int DATA_WIDTH = LANE_NUM * LANE_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_holding_reg, addr_holding_next;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [LANE_NUM-1:0]   lane_we;
  logic [LANE_NUM-1:0]   lane_sel;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  init_busy;
  logic                  init_done;

  // Only the top bit of each lane's WEN slice controls that lane.
  generate
    for (genvar gi = 0; gi < LANE_NUM; gi++) begin : g_lane_sel
      assign lane_sel[gi] = ~bus.WEN[(gi+1)*LANE_WIDTH-1];
    end
  endgenerate

  // State, sweep counter and held address; reset restarts the sweep at 0.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_reg        <= INIT;
      cnt_reg          <= '0;
      addr_holding_reg <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      addr_holding_reg <= addr_holding_next;
    end
  end

  // Next state, RAM address/data/enables and handshake outputs.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    addr_holding_next = addr_holding_reg;
    ram_addr          = addr_holding_reg;
    ram_din           = bus.D;
    lane_we           = '0;
    init_busy         = 1'b1;
    init_done         = 1'b0;

    case (state_reg)
      INIT: begin
        // Functional inputs are ignored; writes are suppressed while in reset.
        ram_addr  = cnt_reg;
        ram_din   = {LANE_NUM{INIT_VALUE}};
        lane_we   = {LANE_NUM{RST_B}};
        init_busy = 1'b1;
        if (cnt_reg == {ADDR_WIDTH{1'b1}}) begin
          init_done  = RST_B;
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + ADDR_WIDTH'(1);
        end
      end

      READY: begin
        init_busy = ~RST_B;
        if (!bus.CEN) begin
          ram_addr          = bus.A;
          addr_holding_next = bus.A;
        end
        lane_we = {LANE_NUM{RST_B & ~bus.CEN & ~bus.GWEN}} & lane_sel;
        // The access in the request cycle still completes normally.
        if (bus.INIT_REQ) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end

      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < LANE_NUM; gi++) begin : g_lane
      fpga_ram #(
        .WIDTH      (LANE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
        .clk  (CLK),
        .we   (lane_we[gi]),
        .addr (ram_addr),
        .din  (ram_din[gi*LANE_WIDTH +: LANE_WIDTH]),
        .dout (ram_q[gi*LANE_WIDTH +: LANE_WIDTH])
      );
    end
  endgenerate

  assign bus.Q         = ram_q;
  assign bus.INIT_BUSY = init_busy;
  assign bus.INIT_DONE = init_done;
endmodule
